// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation run controller: FSM states and the
// host-side record of one dump beat.
package sim_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DUMP_RD,
        ST_DUMP_WAIT,
        ST_DUMP_OUT,
        ST_DONE
    } sim_ctrl_state_e;

    // Widest field sizes a host may see; narrower instances zero-extend.
    localparam int BEAT_TGT_W  = 8;
    localparam int BEAT_ADDR_W = 16;
    localparam int BEAT_DATA_W = 64;

    typedef struct packed {
        logic [BEAT_TGT_W-1:0]  tgt;
        logic [BEAT_ADDR_W-1:0] addr;
        logic [BEAT_DATA_W-1:0] data;
        logic                   last;
    } dump_beat_t;

endpackage

// File: rtl/sim_ctrl_dump_seq.sv
// Dump sweep counter: address runs fastest, target advances on address wrap,
// explicit compares so non-power-of-two sizes wrap cleanly.
module sim_ctrl_dump_seq #(
    parameter int  N_TGT = 4,
    parameter int  DEPTH = 1024,
    localparam int TW    = $clog2(N_TGT),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [TW-1:0] tgt,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [TW-1:0] TGT_MAX  = TW'(N_TGT - 1);
    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);

    assign last = (tgt == TGT_MAX) && (addr == ADDR_MAX);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            tgt  <= '0;
            addr <= '0;
        end else if (adv) begin
            if (addr == ADDR_MAX) begin
                addr <= '0;
                tgt  <= (tgt == TGT_MAX) ? '0 : tgt + 1'b1;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sim_ctrl_engine.sv
// Run controller: streams images into target memories, runs the core to halt
// or watchdog timeout, then dumps every target. Define SIM_CTRL_SIG_EN for a signature output.
module sim_ctrl_engine
    import sim_ctrl_pkg::*;
#(
    parameter int  N_TGT      = 4,
    parameter int  DEPTH      = 1024,
    parameter int  DW         = 32,
    parameter int  MAX_CYCLES = 10000,
    parameter int  CW         = 32,
    localparam int TW         = $clog2(N_TGT),
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [TW-1:0]       ld_tgt,
    input  logic [AW-1:0]       ld_addr,
    input  logic [DW-1:0]       ld_data,
    input  logic                ld_last,
    output logic                core_rst_n,
    output logic                core_en,
    input  logic                core_halt,
    output logic [N_TGT-1:0]    mem_we,
    output logic [N_TGT-1:0]    mem_re,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [N_TGT*DW-1:0] mem_rdata,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [TW-1:0]       dump_tgt,
    output logic [AW-1:0]       dump_addr,
    output logic [DW-1:0]       dump_data,
    output logic                dump_last,
    output logic [CW-1:0]       cyc_cnt,
    output logic                timeout,
    output logic                ld_err,
`ifdef SIM_CTRL_SIG_EN
    output logic [DW-1:0]       sig,
`endif
    output logic                done
);

    localparam logic [CW-1:0] CYC_LIMIT = CW'(MAX_CYCLES - 1);

    sim_ctrl_state_e state, state_nxt;
    logic [TW-1:0]   seq_tgt;
    logic [AW-1:0]   seq_addr;
    logic            seq_last;
    logic            start_ok, ld_fire, ld_bad, dump_fire;
    logic [CW-1:0]   cyc_inc;
    logic [AW-1:0]   wr_addr_p1;
    logic [DW-1:0]   wr_data_p1;
    logic [DW-1:0]   rd_data_p2;

    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign ld_fire   = ld_valid && ld_ready;
    assign ld_bad    = 32'(ld_tgt) >= N_TGT;
    assign dump_fire = dump_valid && dump_ready;
    assign cyc_inc   = cyc_cnt + 1'b1;

    sim_ctrl_dump_seq #(.N_TGT(N_TGT), .DEPTH(DEPTH)) u_seq (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .adv  (dump_fire),
        .tgt  (seq_tgt),
        .addr (seq_addr),
        .last (seq_last)
    );

    always_comb begin
        state_nxt  = state;
        ld_ready   = 1'b0;
        core_rst_n = 1'b1;
        core_en    = 1'b0;
        mem_re     = '0;
        dump_valid = 1'b0;
        dump_last  = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                core_rst_n = 1'b0;
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                core_rst_n = 1'b0;
                ld_ready   = 1'b1;
                if (ld_valid && ld_last) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                core_en = 1'b1;
                if (core_halt || (cyc_inc == CYC_LIMIT)) state_nxt = ST_DUMP_RD;
            end
            ST_DUMP_RD: begin
                mem_re    = N_TGT'(1) << seq_tgt;
                state_nxt = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: state_nxt = ST_DUMP_OUT;
            ST_DUMP_OUT: begin
                dump_valid = 1'b1;
                dump_last  = seq_last;
                if (dump_ready) state_nxt = seq_last ? ST_DONE : ST_DUMP_RD;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read address only matters in DUMP_RD; otherwise present the pending write.
    assign mem_addr  = (state == ST_DUMP_RD) ? seq_addr : wr_addr_p1;
    assign mem_wdata = wr_data_p1;
    assign dump_tgt  = seq_tgt;
    assign dump_addr = seq_addr;
    assign dump_data = rd_data_p2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            mem_we  <= '0;
            cyc_cnt <= '0;
            timeout <= 1'b0;
            ld_err  <= 1'b0;
        end else begin
            state  <= state_nxt;
            mem_we <= (ld_fire && !ld_bad) ? (N_TGT'(1) << ld_tgt) : '0;
            if (start_ok) begin
                cyc_cnt <= '0;
                timeout <= 1'b0;
                ld_err  <= 1'b0;
            end
            if (ld_fire && ld_bad) ld_err <= 1'b1;
            // A halting cycle is not counted and pre-empts the watchdog.
            if ((state == ST_RUN) && !core_halt) begin
                cyc_cnt <= cyc_inc;
                if (cyc_inc == CYC_LIMIT) timeout <= 1'b1;
            end
        end
    end

    // p1: load write stage; p2: read-data capture one cycle after mem_re.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            wr_addr_p1 <= ld_addr;
            wr_data_p1 <= ld_data;
        end
        if (state == ST_DUMP_WAIT) rd_data_p2 <= mem_rdata[seq_tgt*DW +: DW];
    end

`ifdef SIM_CTRL_SIG_EN
    always_ff @(posedge clk) begin
        if (!rst || start_ok) sig <= '0;
        else if (dump_fire)   sig <= {sig[DW-2:0], sig[DW-1]} ^ rd_data_p2;
    end
`endif

endmodule
